frame_sampler: RTL and testbench
================================

Name: frame_sampler

Overview:
- Threshold sampler between a frame SRAM (read side) and a sample SRAM (write side).
- On an `enable` pulse it scans FRAME_WORDS 32-bit frame words. Each word holds two unsigned 16-bit samples.
- Every sample with value >= `threshold` is written, compacted, as one 32-bit entry {sample index, sample value} into the sample SRAM.
- Pulses nothing else; raises `done` when the scan completes.

Parameters:
- FRAME_WORDS, 8: number of frame words scanned per run (1..8192).
- FRAME_BASE, 0: first frame SRAM word address.
- SAMPLE_BASE, 0: first sample SRAM word address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start pulse; sampled only in IDLE/DONE.
- threshold  in  16  unsigned threshold; latched on start.
- fdata  in  32  frame SRAM read data; valid the cycle after the address is presented with `load`=1.
- faddr  out  14  frame SRAM word address.
- load  out  1  frame SRAM output enable (OE), active-high.
- saddr  out  14  sample SRAM write address.
- sdata  out  32  sample SRAM write data.
- store  out  1  sample SRAM write enable (WEB), active-low; 0 = write on this rising edge.
- done  out  1  scan complete, level.

Behaviour:
- Reset values, applied asynchronously while `rst`=0:
  - done=0, load=0, store=1.
  - sdata=0, saddr=SAMPLE_BASE, faddr=FRAME_BASE.
  - FSM enters IDLE; counters cleared.
- FSM states: IDLE, READ, WAIT, EVAL_HI, EVAL_LO, DONE.
- IDLE/DONE, `enable`=1:
  - Latch `threshold`.
  - Clear word counter w and write pointer p.
  - Clear `done`; go to READ.
  - `enable` in any other state is ignored.
- READ: faddr=FRAME_BASE+w, load=1 → WAIT.
- WAIT:
  - faddr held, load=1.
  - At the end of the cycle, capture `fdata` into a word register → EVAL_HI.
- EVAL_HI: hi = word[31:16], index = 2w.
  - If hi >= threshold (unsigned): store=0, saddr=SAMPLE_BASE+p, sdata={index[15:0], hi}, and p increments.
  - Otherwise store=1.
  - → EVAL_LO.
- EVAL_LO: same rule with lo = word[15:0], index = 2w+1.
  - Then, if w == FRAME_WORDS-1 → DONE; else w++ → READ.
- DONE: done=1 (held), store=1, load=0; waits for the next `enable`.
- Outside the states where they are driven:
  - `load`=0 and `store`=1 in all other states.
  - `sdata`/`saddr` hold their last value.
- Timing:
  - Exactly 4 cycles per frame word.
  - `done` rises 4*FRAME_WORDS+1 cycles after the `enable` edge.
- Comparison rules:
  - Equality passes.
  - threshold=0 passes every sample.
  - threshold=16'hFFFF passes only 16'hFFFF.
- Write pointer `p` wraps modulo 2^14. Index is truncated to 16 bits.
- Reset mid-scan: immediate return to IDLE with reset output values. No partial-state resume.

Optional Feature:
- Macro: SAMPLE_COUNT_EN.
- Defined: after EVAL_LO of the last word, an extra TRAILER cycle writes {16'hFFFF, count[15:0]} at SAMPLE_BASE+p (store=0), then → DONE. `done` rises one cycle later.
- Undefined: no trailer; EVAL_LO goes straight to DONE.

Decomposition:
- Package `frame_sampler_pkg`:
  - state enum.
  - ENTRY_W=32, HALF_W=16, ADDR_W=14.
  - trailer tag 16'hFFFF.
- One sub-module `sample_select`, purely combinational:
  - Inputs: halfword, threshold, index.
  - Outputs: pass flag and packed entry.

Test Plan:
- Frame words 00410006, 00150056, 00560015, 00050006, 00350056, 00040002, 00550088, 00150056; threshold=20; enable pulse → exactly 11 writes at saddr 0..10:
  - 00000041, 00020015, 00030056, 00040056, 00050015
  - 00080035, 00090056, 000C0055, 000D0088, 000E0015, 000F0056
  - `done`=1 at cycle 33 after enable.
- Same frame, threshold=16'h0015 → the 21 (0x15) samples are still written, confirming equality passes.
- Threshold=16'hFFFF → no write (store stays 1); `done` still asserts after 33 cycles.
- `enable` asserted again mid-scan → ignored, identical results. Second `enable` after DONE → `done` drops, rescan, same writes from saddr 0.
- `rst` low in the middle of a scan → outputs immediately done=0, load=0, store=1; next `enable` runs a clean full scan.
- SAMPLE_COUNT_EN defined → extra write FFFF000B at saddr 11; `done` at cycle 34.

Source files
------------

// File: rtl/frame_sampler_pkg.sv
// Shared types and widths for the frame threshold sampler.
package frame_sampler_pkg;

  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned ADDR_W  = 14;

  localparam logic [HALF_W-1:0] TRAILER_TAG = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL_HI,
    EVAL_LO,
    DONE,
    TRAILER
  } state_t;

  // One compacted sample-SRAM entry.
  typedef struct packed {
    logic [HALF_W-1:0] index;
    logic [HALF_W-1:0] value;
  } entry_t;

endpackage

// File: rtl/frame_sampler_select.sv
// Threshold compare and entry packing for one 16-bit sample.
module sample_select
  import frame_sampler_pkg::*;
(
  input  logic [HALF_W-1:0] half,
  input  logic [HALF_W-1:0] thr,
  input  logic [HALF_W-1:0] idx,
  output logic              pass_c,
  output entry_t            entry_c
);

  // Unsigned compare; equality passes.
  always_comb begin
    pass_c        = (half >= thr);
    entry_c.index = idx;
    entry_c.value = half;
  end

endmodule

// File: rtl/frame_sampler.sv
// Frame threshold sampler: scans FRAME_WORDS words of two samples each and
// writes every sample >= threshold, compacted, into the sample SRAM.
// Optional: define SAMPLE_COUNT_EN to append a {FFFF, count} trailer entry.
module frame_sampler
  import frame_sampler_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 8,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int unsigned SAMPLE_BASE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [HALF_W-1:0]  threshold,
  input  logic [ENTRY_W-1:0] fdata,
  output logic [ADDR_W-1:0]  faddr,
  output logic               load,
  output logic [ADDR_W-1:0]  saddr,
  output logic [ENTRY_W-1:0] sdata,
  output logic               store,
  output logic               done
);

  localparam int unsigned W_W = 13;

  state_t              state_q, state_d;
  logic [W_W-1:0]      w_q, w_d;
  logic [ADDR_W-1:0]   p_q, p_d;
  logic [HALF_W-1:0]   thr_q, thr_d;
  logic [HALF_W-1:0]   word_lo_q, word_lo_d;
  logic                done_d, load_d, store_d;
  logic [ENTRY_W-1:0]  sdata_d;
  logic [ADDR_W-1:0]   saddr_d, faddr_d;
`ifdef SAMPLE_COUNT_EN
  logic [HALF_W-1:0]   cnt_q, cnt_d;
`endif

  logic [HALF_W-1:0]   sel_half, sel_idx;
  logic                sel_pass;
  entry_t              sel_entry;

  // High half comes straight off the SRAM bus while the word is captured.
  always_comb begin
    sel_half = (state_q == WAIT) ? fdata[31:16] : word_lo_q;
    sel_idx  = (state_q == WAIT) ? HALF_W'({w_q, 1'b0}) : HALF_W'({w_q, 1'b1});
  end

  sample_select u_select (
    .half    (sel_half),
    .thr     (thr_q),
    .idx     (sel_idx),
    .pass_c  (sel_pass),
    .entry_c (sel_entry)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      w_q       <= '0;
      p_q       <= '0;
      thr_q     <= '0;
      word_lo_q <= '0;
      done      <= 1'b0;
      load      <= 1'b0;
      store     <= 1'b1;
      sdata     <= '0;
      saddr     <= ADDR_W'(SAMPLE_BASE);
      faddr     <= ADDR_W'(FRAME_BASE);
`ifdef SAMPLE_COUNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      p_q       <= p_d;
      thr_q     <= thr_d;
      word_lo_q <= word_lo_d;
      done      <= done_d;
      load      <= load_d;
      store     <= store_d;
      sdata     <= sdata_d;
      saddr     <= saddr_d;
      faddr     <= faddr_d;
`ifdef SAMPLE_COUNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next state and next output values for the state being entered.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    p_d       = p_q;
    thr_d     = thr_q;
    word_lo_d = word_lo_q;
    done_d    = done;
    load_d    = 1'b0;
    store_d   = 1'b1;
    sdata_d   = sdata;
    saddr_d   = saddr;
    faddr_d   = faddr;
`ifdef SAMPLE_COUNT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          thr_d   = threshold;
          w_d     = '0;
          p_d     = '0;
`ifdef SAMPLE_COUNT_EN
          cnt_d   = '0;
`endif
          done_d  = 1'b0;
          faddr_d = ADDR_W'(FRAME_BASE);
          load_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        load_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        word_lo_d = fdata[15:0];
        state_d   = EVAL_HI;
      end
      EVAL_HI: begin
        state_d = EVAL_LO;
      end
      EVAL_LO: begin
        if (w_q == W_W'(FRAME_WORDS - 1)) begin
`ifdef SAMPLE_COUNT_EN
          store_d = 1'b0;
          saddr_d = ADDR_W'(SAMPLE_BASE) + p_q;
          sdata_d = {TRAILER_TAG, cnt_q};
          state_d = TRAILER;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          w_d     = w_q + 1'b1;
          faddr_d = ADDR_W'(FRAME_BASE) + ADDR_W'(w_q + 1'b1);
          load_d  = 1'b1;
          state_d = READ;
        end
      end
      TRAILER: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Write a passing sample during the following EVAL cycle.
    if ((state_q == WAIT || state_q == EVAL_HI) && sel_pass) begin
      store_d = 1'b0;
      saddr_d = ADDR_W'(SAMPLE_BASE) + p_q;
      sdata_d = sel_entry;
      p_d     = p_q + 1'b1;
`ifdef SAMPLE_COUNT_EN
      cnt_d   = cnt_q + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_frame_sampler.sv
// Scoreboard bench for frame_sampler.
module tb_frame_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] threshold = '0;
  logic [31:0] fdata = '0;
  logic [13:0] faddr, saddr;
  logic [31:0] sdata;
  logic        load, store, done;

`ifdef SAMPLE_COUNT_EN
  localparam int DONE_CYC = 34;
`else
  localparam int DONE_CYC = 33;
`endif

  always #5 clk = ~clk;

  frame_sampler #(.FRAME_WORDS(8), .FRAME_BASE(0), .SAMPLE_BASE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .threshold (threshold),
    .fdata     (fdata),
    .faddr     (faddr),
    .load      (load),
    .saddr     (saddr),
    .sdata     (sdata),
    .store     (store),
    .done      (done)
  );

  logic [31:0] frame [8];
  logic [45:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  // Frame SRAM: registered read while OE is high.
  always @(posedge clk) if (load) fdata <= frame[faddr[2:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare every sample SRAM write against the scoreboard.
  always @(negedge clk) begin
    logic [45:0] e;
    if (rst && store === 1'b0) begin
      n_writes++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write", 64'({saddr, sdata}), 64'(e));
      end
    end
  end

  task automatic build_expected(input logic [15:0] thr, output int n);
    logic [15:0] v;
    int p;
    p = 0;
    for (int w = 0; w < 8; w++) begin
      for (int h = 0; h < 2; h++) begin
        v = (h == 0) ? frame[w][31:16] : frame[w][15:0];
        if (v >= thr) begin
          exp_q.push_back({14'(p), 16'(2 * w + h), v});
          p++;
        end
      end
    end
`ifdef SAMPLE_COUNT_EN
    exp_q.push_back({14'(p), 16'hFFFF, 16'(p)});
    p++;
`endif
    n = p;
  endtask

  task automatic run_scan(input logic [15:0] thr, input int mid_en_at, input int abort_at);
    int edges;
    int exp_n;
    exp_q.delete();
    build_expected(thr, exp_n);
    n_writes = 0;
    @(negedge clk);
    threshold = thr;
    enable    = 1'b1;
    @(negedge clk);
    enable    = 1'b0;
    threshold = ~thr;
    edges     = 1;
    check("done_clear", 64'(done), 64'(0));
    while (!done && edges < 200) begin
      if (abort_at != 0 && edges == abort_at) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_done", 64'(done), 64'(0));
        check("rst_load", 64'(load), 64'(0));
        check("rst_store", 64'(store), 64'(1));
        check("rst_addr", 64'({faddr, saddr}), 64'(0));
        check("rst_sdata", 64'(sdata), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      enable = (edges == mid_en_at);
      @(negedge clk);
      edges++;
    end
    enable = 1'b0;
    check("done_cycle", 64'(edges), 64'(DONE_CYC));
    check("write_count", 64'(n_writes), 64'(exp_n));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk);
    check("done_held", 64'({done, store, load}), 64'(3'b110));
  endtask

  initial begin
    frame[0] = 32'h00410006; frame[1] = 32'h00150056;
    frame[2] = 32'h00560015; frame[3] = 32'h00050006;
    frame[4] = 32'h00350056; frame[5] = 32'h00040002;
    frame[6] = 32'h00550088; frame[7] = 32'h00150056;
    #12;
    check("reset_ctrl", 64'({done, load, store}), 64'(3'b001));
    check("reset_addr", 64'({faddr, saddr}), 64'(0));
    check("reset_sdata", 64'(sdata), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    run_scan(16'd20, 0, 0);
    run_scan(16'h0015, 0, 0);
    run_scan(16'hFFFF, 0, 0);
    run_scan(16'h0000, 0, 0);
    run_scan(16'd20, 10, 0);
    run_scan(16'd20, 0, 0);
    run_scan(16'd20, 0, 14);
    run_scan(16'd20, 0, 0);
    frame[0] = 32'hFFFF0001;
    run_scan(16'hFFFF, 0, 0);
    run_scan(16'h0056, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
